// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus decoder: synchronises and glitch-filters SCL/SDA, then decodes
// START / repeated START / BYTE+ACK / STOP into a small event FIFO with valid/ready.
module i2c_bus_monitor #(
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       ICE_CLK,
  input  logic       ICE_RST_N,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_type,
  output logic [7:0] evt_data,
  output logic       evt_ack,
  output logic       bus_busy,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] EV_START  = 2'b00;
  localparam logic [1:0] EV_RSTART = 2'b01;
  localparam logic [1:0] EV_BYTE   = 2'b10;
  localparam logic [1:0] EV_STOP   = 2'b11;

  typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

  // Index 1 = SCL, index 0 = SDA
  logic [1:0] raw, s1, s2, filt, filt_q;
  logic [3:0] fcnt [2];

  assign raw = {scl_di, sda_di};

  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      s1      <= '1;
      s2      <= '1;
      filt    <= '1;
      filt_q  <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      filt_q <= filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 4'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, start_det, stop_det;

  assign scl_f = filt[1];
  assign sda_f = filt[0];
  assign scl_p = filt_q[1];
  assign sda_p = filt_q[0];

  // SCL high in both cycles excludes simultaneous SCL edges from START/STOP
  assign scl_rise  = scl_f & ~scl_p;
  assign start_det = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        push_q;
  logic [10:0] push_word;

  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
      bus_busy  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            push_q    <= 1'b1;
            push_word <= {EV_START, 8'h00, 1'b0};
            bus_busy  <= 1'b1;
            bit_cnt   <= '0;
            state     <= BITS;
          end
        end
        BITS, ACK: begin
          if (start_det) begin
            push_q    <= 1'b1;
            push_word <= {EV_RSTART, 8'h00, 1'b0};
            bit_cnt   <= '0;
            state     <= BITS;
          end else if (stop_det) begin
            push_q    <= 1'b1;
            push_word <= {EV_STOP, 8'h00, 1'b0};
            bus_busy  <= 1'b0;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else if (scl_rise) begin
            if (state == BITS) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) state <= ACK;
            end else begin
              push_q    <= 1'b1;
              push_word <= {EV_BYTE, shreg, ~sda_f};
              bit_cnt   <= '0;
              state     <= BITS;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop, drop;
  logic [10:0]   head_nxt;

  // Output registers are loaded from the post-update FIFO state so that the
  // head shown is always coherent with the pop that just happened.
  always_comb begin
    do_pop    = evt_ready & (count != '0);
    do_push   = push_q & ((count != (AW+1)'(FIFO_DEPTH)) | do_pop);
    drop      = push_q & (count == (AW+1)'(FIFO_DEPTH)) & ~do_pop;
    rd_nxt    = rd_ptr + AW'(do_pop);
    count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_nxt  = '0;
    if (count_nxt != '0) begin
      if (do_push && (wr_ptr == rd_nxt)) head_nxt = push_word;
      else                                head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge ICE_CLK) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_type  <= '0;
      evt_data  <= '0;
      evt_ack   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      evt_valid <= (count_nxt != '0);
      {evt_type, evt_data, evt_ack} <= head_nxt;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: drives I2C transactions and checks the event stream
// against an event list built from bus-level rules.
module tb_i2c_bus_monitor;

  localparam int P     = 40;
  localparam int FL    = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       ready = 1'b1;
  logic       oclr = 1'b0;
  logic       evt_valid, evt_ack, bus_busy, overflow;
  logic [1:0] evt_type;
  logic [7:0] evt_data;

  always #5 clk = ~clk;

  i2c_bus_monitor #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .ICE_CLK(clk), .ICE_RST_N(rst_n), .scl_di(scl), .sda_di(sda),
    .evt_valid(evt_valid), .evt_ready(ready), .evt_type(evt_type),
    .evt_data(evt_data), .evt_ack(evt_ack), .bus_busy(bus_busy),
    .overflow(overflow), .overflow_clr(oclr)
  );

  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit model_busy = 1'b0;

  always @(negedge clk)
    if (rst_n && evt_valid && ready) obs_q.push_back({evt_type, evt_data, evt_ack});

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks also record the events a correct monitor must report.
  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda = 1'b1; cyc(P);
      scl = 1'b1; cyc(P);
    end else begin
      sda = 1'b1; cyc(P);
    end
    sda = 1'b0; cyc(P);
    scl = 1'b0; cyc(P);
    exp_q.push_back({model_busy ? 2'b01 : 2'b00, 8'h00, 1'b0});
    model_busy = 1'b1;
  endtask

  task automatic i2c_bit(input logic b);
    sda = b;    cyc(P);
    scl = 1'b1; cyc(P);
    scl = 1'b0; cyc(P);
  endtask

  task automatic i2c_byte(input logic [7:0] b, input logic ack);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
    i2c_bit(~ack);
    if (model_busy) exp_q.push_back({2'b10, b, ack});
  endtask

  task automatic i2c_stop();
    sda = 1'b0; cyc(P);
    scl = 1'b1; cyc(P);
    sda = 1'b1; cyc(P);
    if (model_busy) exp_q.push_back({2'b11, 8'h00, 1'b0});
    model_busy = 1'b0;
  endtask

  task automatic compare(input string tag);
    int n;
    cyc(30);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_evt%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [10:0] head;
    cyc(5);
    chk("rst_valid", evt_valid, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_ack", evt_ack, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    cyc(10);

    // Write 0xA4 ACK, STOP
    i2c_start();
    chk("wr_busy_on", bus_busy, 1);
    i2c_byte(8'hA4, 1'b1);
    i2c_stop();
    chk("wr_busy_off", bus_busy, 0);
    compare("wr");

    // Read: 0x51 ACK, 0x3C NACK
    i2c_start();
    i2c_byte(8'h51, 1'b1);
    i2c_byte(8'h3C, 1'b0);
    i2c_stop();
    compare("rd");

    // Partial byte abandoned by repeated START
    i2c_start();
    for (int i = 0; i < 4; i++) i2c_bit($urandom_range(0, 1));
    i2c_start();
    i2c_byte(8'hFF, 1'b1);
    i2c_stop();
    compare("rs");

    // Glitches shorter than the filter are invisible
    sda = 1'b0; cyc(2); sda = 1'b1; cyc(20);
    scl = 1'b0; cyc(2); scl = 1'b1; cyc(20);
    chk("glitch_busy", bus_busy, 0);
    compare("glitch");
    // A pulse of exactly FILTER_LEN is a START, its trailing edge a STOP
    sda = 1'b0; cyc(FL); sda = 1'b1;
    exp_q.push_back({2'b00, 8'h00, 1'b0});
    exp_q.push_back({2'b11, 8'h00, 1'b0});
    compare("pulse");

    // Overflow: 10 events into an 8-entry FIFO
    ready = 1'b0;
    i2c_start();
    for (int i = 0; i < 8; i++) i2c_byte(8'($urandom), 1'($urandom));
    i2c_stop();
    cyc(20);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", evt_valid, 1);
    head = {evt_type, evt_data, evt_ack};
    chk("ovf_head", head, exp_q[0]);
    cyc(10);
    chk("ovf_hold", {evt_type, evt_data, evt_ack}, head);
    ready = 1'b1;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    compare("ovf");
    chk("ovf_sticky", overflow, 1);
    oclr = 1'b1; cyc(1); oclr = 1'b0;
    chk("ovf_clr", overflow, 0);
    chk("drained", evt_valid, 0);

    // Random traffic
    for (int t = 0; t < 3; t++) begin
      i2c_start();
      for (int b = 0, nb = $urandom_range(1, 2); b < nb; b++)
        i2c_byte(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        i2c_start();
        i2c_byte(8'($urandom), 1'($urandom));
      end
      i2c_stop();
      compare($sformatf("rnd%0d", t));
    end

    // Reset mid-byte
    i2c_start();
    for (int i = 0; i < 4; i++) i2c_bit($urandom_range(0, 1));
    compare("pre_rst");
    rst_n = 1'b0;
    cyc(2);
    scl = 1'b1; sda = 1'b1; model_busy = 1'b0;
    chk("mid_valid", evt_valid, 0);
    chk("mid_type", evt_type, 0);
    chk("mid_data", evt_data, 0);
    chk("mid_ack", evt_ack, 0);
    chk("mid_busy", bus_busy, 0);
    chk("mid_ovf", overflow, 0);
    cyc(5);
    rst_n = 1'b1;
    cyc(10);
    for (int i = 0; i < 9; i++) begin
      scl = 1'b0; cyc(P);
      sda = 1'($urandom); cyc(P);
      scl = 1'b1; cyc(P);
    end
    scl = 1'b0; cyc(P);
    sda = 1'b1; cyc(P);
    scl = 1'b1; cyc(P);
    chk("post_rst_busy", bus_busy, 0);
    compare("post_rst");
    i2c_start();
    i2c_byte(8'h5A, 1'b1);
    i2c_stop();
    compare("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
